// File: rtl/hazard_controller_pkg.sv
// hazard_controller_pkg: shared pipeline types and constants for the LEGv8 hazard logic
package hazard_controller_pkg;

    typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [4:0] XZR     = 5'd31;

    // XZR is hard-wired zero, so it never matches as a producer or consumer
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != XZR);
    endfunction

endpackage

// File: rtl/hazard_controller_fwd.sv
// forwarding_unit: EX-stage operand bypass selects, EX/MEM result preferred over MEM/WB
module forwarding_unit
    import hazard_controller_pkg::*;
(
    input  logic [4:0] RA_EX,
    input  logic [4:0] RB_EX,
    input  logic [4:0] RD_MEM,
    input  logic       RegWrite_MEM,
    input  logic [4:0] RD_WB,
    input  logic       RegWrite_WB,
    output logic [1:0] FwdA,
    output logic [1:0] FwdB
);

    always_comb begin
        FwdA = (RegWrite_MEM && reg_match(RD_MEM, RA_EX)) ? FWD_MEM :
               (RegWrite_WB  && reg_match(RD_WB,  RA_EX)) ? FWD_WB  : FWD_RF;
        FwdB = (RegWrite_MEM && reg_match(RD_MEM, RB_EX)) ? FWD_MEM :
               (RegWrite_WB  && reg_match(RD_WB,  RB_EX)) ? FWD_WB  : FWD_RF;
    end

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, taken-branch flush, forwarding selects and perf counters
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int CNT_W           = 32
)
(
    input  logic             clk,
    input  logic             resetl,
    input  logic [4:0]       RA_ID,
    input  logic [4:0]       RB_ID,
    input  logic             UseA_ID,
    input  logic             UseB_ID,
    input  logic [4:0]       RD_EX,
    input  logic             MemRead_EX,
    input  logic             RegWrite_EX,
    input  logic [4:0]       RA_EX,
    input  logic [4:0]       RB_EX,
    input  logic [4:0]       RD_MEM,
    input  logic             RegWrite_MEM,
    input  logic [4:0]       RD_WB,
    input  logic             RegWrite_WB,
    input  logic             BranchTaken_MEM,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXBubble,
    output logic             FlushIFID,
    output logic             FlushIDEX,
    output logic             FlushEXMEM,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [2:0] CNT_LOAD = 3'(LU_STALL_CYCLES - 1);

    hz_state_t  state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       hazard, stall, flush;

    assign hazard = MemRead_EX && RegWrite_EX &&
                    ((UseA_ID && reg_match(RA_ID, RD_EX)) || (UseB_ID && reg_match(RB_ID, RD_EX)));

    // The hazard cycle itself is the first bubble; LU_STALL supplies the remaining ones
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall   = 1'b0;
        flush   = 1'b0;
        if (BranchTaken_MEM) begin
            flush   = 1'b1;
            state_n = FLUSH;
        end else if (state == LU_STALL) begin
            stall   = 1'b1;
            cnt_n   = cnt - 3'd1;
            state_n = (cnt == 3'd1) ? RUN : LU_STALL;
        end else if (state == FLUSH) begin
            state_n = RUN;
        end else if (hazard) begin
            stall   = 1'b1;
            cnt_n   = CNT_LOAD;
            state_n = (LU_STALL_CYCLES > 1) ? LU_STALL : RUN;
        end
    end

    assign PCWrite    = !stall;
    assign IFIDWrite  = !stall;
    assign IDEXBubble = stall;
    assign FlushIFID  = flush;
    assign FlushIDEX  = flush;
    assign FlushEXMEM = flush;

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state      <= RUN;
            cnt        <= 3'd0;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            StallCount <= StallCount + CNT_W'(stall);
            FlushCount <= FlushCount + CNT_W'(BranchTaken_MEM);
        end
    end

    forwarding_unit u_fwd (
        .RA_EX        (RA_EX),
        .RB_EX        (RB_EX),
        .RD_MEM       (RD_MEM),
        .RegWrite_MEM (RegWrite_MEM),
        .RD_WB        (RD_WB),
        .RegWrite_WB  (RegWrite_WB),
        .FwdA         (FwdA),
        .FwdB         (FwdB)
    );

endmodule
